// File: rtl/fir_ctrl.sv
// Sequencing controller for the 15-tap FIR: sample-strobe divider, coefficient-set
// select with flush on band change, and pipeline-aligned output valid. Optional: FIR_CTRL_WARMUP_EN.
module fir_ctrl #(
  parameter int unsigned CNT_WW    = 16,
  parameter int unsigned FLUSH_CYC = 4,
  parameter int unsigned LAT       = 3,
  parameter logic [1:0]  BAND_RST  = 2'd1
) (
  input  logic              clk,
  input  logic              i_rst,
  input  logic              i_run,
  input  logic [CNT_WW-1:0] i_div,
  input  logic              i_band_req,
  input  logic [1:0]        i_band_sel,
  output logic              o_fir_en,
  output logic              o_fir_srst,
  output logic [1:0]        o_coeff_sel,
  output logic              o_band_ack,
  output logic              o_band_err,
  output logic              o_valid
);

  localparam int unsigned    FW         = $clog2(FLUSH_CYC + 1);
  localparam logic [FW-1:0]  FLUSH_LAST = FW'(FLUSH_CYC - 1);

  typedef enum logic [1:0] {IDLE, FLUSH, RUN} state_e;

  state_e              state_q, state_d;
  logic                srst_q, srst_d;
  logic                en_q, en_d;
  logic                ack_q, ack_d;
  logic                err_q, err_d;
  logic [1:0]          coeff_q, coeff_d;
  logic [CNT_WW-1:0]   div_q, div_d;
  logic [FW-1:0]       flush_q, flush_d;
  logic [LAT-1:0]      line_q, line_d;
  logic                warm;
  logic                legal_req;

  assign legal_req = i_band_req && (i_band_sel != 2'd3);

  always_comb begin
    state_d = state_q;
    srst_d  = srst_q;
    en_d    = 1'b0;
    ack_d   = 1'b0;
    err_d   = i_band_req && (i_band_sel == 2'd3);
    coeff_d = coeff_q;
    div_d   = div_q;
    flush_d = flush_q;
    unique case (state_q)
      IDLE: begin
        srst_d  = 1'b1;
        div_d   = '0;
        flush_d = '0;
        if (legal_req) begin
          coeff_d = i_band_sel;
          ack_d   = 1'b1;
        end
        if (i_run) state_d = FLUSH;
      end
      FLUSH: begin
        srst_d = 1'b1;
        div_d  = '0;
        if (!i_run) begin
          state_d = IDLE;
        end else if (flush_q == FLUSH_LAST) begin
          state_d = RUN;
          srst_d  = 1'b0;
        end else begin
          flush_d = flush_q + FW'(1);
        end
      end
      RUN: begin
        srst_d = 1'b0;
        if (!i_run) begin
          state_d = IDLE;
          srst_d  = 1'b1;
          div_d   = '0;
        end else if (legal_req) begin
          // Even a request for the current set is accepted: it forces a flush.
          state_d = FLUSH;
          srst_d  = 1'b1;
          coeff_d = i_band_sel;
          ack_d   = 1'b1;
          flush_d = '0;
          div_d   = '0;
        end else if (div_q >= i_div) begin
          en_d  = 1'b1;
          div_d = '0;
        end else begin
          div_d = div_q + CNT_WW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        srst_d  = 1'b1;
      end
    endcase
  end

`ifdef FIR_CTRL_WARMUP_EN
  // Strobes since the last flush; the 15th strobe is the first with all delay taps filled.
  localparam logic [3:0] WARM_FULL = 4'd14;
  logic [3:0] warm_q, warm_d;

  always_comb begin
    warm_d = warm_q;
    if (srst_q)                          warm_d = '0;
    else if (en_q && warm_q != WARM_FULL) warm_d = warm_q + 4'd1;
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) warm_q <= '0;
    else       warm_q <= warm_d;
  end

  assign warm = (warm_q == WARM_FULL);
`else
  assign warm = 1'b1;
`endif

  always_comb begin
    line_d = '0;
    if (!srst_q) begin
      line_d[0] = en_q & warm;
      for (int unsigned i = 1; i < LAT; i++) line_d[i] = line_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      srst_q  <= 1'b1;
      en_q    <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      coeff_q <= BAND_RST;
      div_q   <= '0;
      flush_q <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      srst_q  <= srst_d;
      en_q    <= en_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      coeff_q <= coeff_d;
      div_q   <= div_d;
      flush_q <= flush_d;
      line_q  <= line_d;
    end
  end

  assign o_fir_en    = en_q;
  assign o_fir_srst  = srst_q;
  assign o_coeff_sel = coeff_q;
  assign o_band_ack  = ack_q;
  assign o_band_err  = err_q;
  // Gating by srst also drops samples that would emerge during the first flush cycle.
  assign o_valid     = line_q[LAT-1] & ~srst_q;

endmodule

// File: tb/tb_fir_ctrl.sv
// Self-checking bench for fir_ctrl: directed scenarios plus random traffic against a
// rule-level reference model (strobe/flush history decides valid).
module tb_fir_ctrl;

  localparam int unsigned CNT_WW    = 16;
  localparam int unsigned FLUSH_CYC = 4;
  localparam int unsigned LAT       = 3;
  localparam logic [1:0]  BAND_RST  = 2'd1;
  localparam int          HMAX      = 8192;
`ifdef FIR_CTRL_WARMUP_EN
  localparam int          WARM_N    = 15;
`else
  localparam int          WARM_N    = 1;
`endif

  logic              clk = 1'b0;
  logic              i_rst, i_run, i_band_req;
  logic [CNT_WW-1:0] i_div;
  logic [1:0]        i_band_sel;
  logic              o_fir_en, o_fir_srst, o_band_ack, o_band_err, o_valid;
  logic [1:0]        o_coeff_sel;

  fir_ctrl #(.CNT_WW(CNT_WW), .FLUSH_CYC(FLUSH_CYC), .LAT(LAT), .BAND_RST(BAND_RST)) dut (
    .clk(clk), .i_rst(i_rst), .i_run(i_run), .i_div(i_div),
    .i_band_req(i_band_req), .i_band_sel(i_band_sel),
    .o_fir_en(o_fir_en), .o_fir_srst(o_fir_srst), .o_coeff_sel(o_coeff_sel),
    .o_band_ack(o_band_ack), .o_band_err(o_band_err), .o_valid(o_valid)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef enum {M_IDLE, M_FLUSH, M_RUN} mode_t;
  mode_t mode;
  int    flush_left, phase, since_flush, cyc;
  bit    en_h[HMAX];
  bit    srst_h[HMAX];
  bit    warm_h[HMAX];
  logic  e_en, e_srst, e_ack, e_err, e_valid;
  logic [1:0] e_coeff;

  // A strobe LAT cycles ago shows up only if warm and no flush cycle occurred since.
  function automatic logic valid_at(int c);
    if (c < int'(LAT)) return 1'b0;
    if (!en_h[c-int'(LAT)] || !warm_h[c-int'(LAT)]) return 1'b0;
    for (int k = c - int'(LAT) + 1; k <= c; k++) if (srst_h[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    mode        = M_IDLE;
    e_en        = 1'b0;
    e_srst      = 1'b1;
    e_ack       = 1'b0;
    e_err       = 1'b0;
    e_valid     = 1'b0;
    e_coeff     = BAND_RST;
    since_flush = 0;
    flush_left  = 0;
    phase       = 0;
    en_h[cyc]   = 1'b0;
    srst_h[cyc] = 1'b1;
    warm_h[cyc] = 1'b0;
  endtask

  task automatic model_step();
    bit legal;
    legal = i_band_req && (i_band_sel != 2'd3);
    e_err = i_band_req && (i_band_sel == 2'd3);
    e_ack = 1'b0;
    e_en  = 1'b0;
    case (mode)
      M_IDLE: begin
        if (legal) begin e_coeff = i_band_sel; e_ack = 1'b1; end
        if (i_run) begin mode = M_FLUSH; flush_left = int'(FLUSH_CYC); end
      end
      M_FLUSH: begin
        if (!i_run) mode = M_IDLE;
        else begin
          flush_left--;
          if (flush_left == 0) begin mode = M_RUN; phase = 0; end
        end
      end
      M_RUN: begin
        if (!i_run) mode = M_IDLE;
        else if (legal) begin
          e_coeff = i_band_sel; e_ack = 1'b1;
          mode = M_FLUSH; flush_left = int'(FLUSH_CYC);
        end else begin
          phase++;
          if (phase >= int'(i_div) + 1) begin e_en = 1'b1; phase = 0; end
        end
      end
      default: mode = M_IDLE;
    endcase
    e_srst = (mode != M_RUN);
    en_h[cyc]   = e_en;
    srst_h[cyc] = e_srst;
    if (e_srst) since_flush = 0;
    warm_h[cyc] = (since_flush >= WARM_N - 1);
    if (e_en) since_flush++;
    e_valid = valid_at(cyc);
  endtask

  task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0b expected=%0b cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic check_int(input string tag, input int got, input int exp);
    total++;
    assert (got == exp) else begin
      bad++;
      $error("FAIL %s: got=%0d expected=%0d cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic check_all();
    check("fir_en",    {1'b0, o_fir_en},   {1'b0, e_en});
    check("fir_srst",  {1'b0, o_fir_srst}, {1'b0, e_srst});
    check("coeff_sel", o_coeff_sel,        e_coeff);
    check("band_ack",  {1'b0, o_band_ack}, {1'b0, e_ack});
    check("band_err",  {1'b0, o_band_err}, {1'b0, e_err});
    check("valid",     {1'b0, o_valid},    {1'b0, e_valid});
  endtask

  task automatic step();
    @(posedge clk);
    if (cyc < HMAX - 1) cyc++;
    if (i_rst) model_reset();
    else       model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic request(input logic [1:0] sel, input int bound);
    bit got;
    got        = 1'b0;
    i_band_sel = sel;
    i_band_req = 1'b1;
    for (int i = 0; i < bound && !got; i++) begin
      step();
      got = o_band_ack;
    end
    i_band_req = 1'b0;
    check("ack_timeout", {1'b0, got}, 2'b01);
  endtask

  int cnt, cnt2;

  initial begin
    cyc        = 0;
    i_rst      = 1'b1;
    i_run      = 1'b0;
    i_band_req = 1'b0;
    i_band_sel = 2'd0;
    i_div      = 16'd3;
    model_reset();
    #1;
    check_all();
    steps(2);
    i_rst = 1'b0;

    // reset and divider: 4 flush cycles then a strobe every 4th cycle
    i_run = 1'b1;
    cnt   = 0;
    for (int i = 0; i < 5; i++) begin step(); cnt += int'(o_fir_srst); end
    check_int("flush_len", cnt, int'(FLUSH_CYC));
    cnt = 0;
    for (int i = 0; i < 20; i++) begin step(); cnt += int'(o_fir_en); end
    check_int("div3_strobes", cnt, 5);
    steps(6);

    // band change with samples in flight
    i_div = 16'd0;
    steps(6);
    request(2'd2, 20);
    check("coeff_after_ack", o_coeff_sel, 2'd2);
    cnt = 1; cnt2 = int'(o_valid);
    for (int i = 0; i < 7; i++) begin
      step();
      cnt  += int'(o_fir_srst);
      cnt2 += (i < 3) ? int'(o_valid) : 0;
    end
    check_int("band_flush_len", cnt, int'(FLUSH_CYC));
    check_int("flushed_valid", cnt2, 0);
    i_div = 16'd2;
    steps(8);

    // illegal band held for three cycles
    i_band_sel = 2'd3;
    i_band_req = 1'b1;
    cnt = 0; cnt2 = 0;
    for (int i = 0; i < 3; i++) begin step(); cnt += int'(o_band_err); cnt2 += int'(o_band_ack); end
    i_band_req = 1'b0;
    for (int i = 0; i < 2; i++) begin step(); cnt += int'(o_band_err); cnt2 += int'(o_band_ack); end
    check_int("illegal_err_pulses", cnt, 3);
    check_int("illegal_no_ack", cnt2, 0);
    check("illegal_coeff", o_coeff_sel, 2'd2);

    // warm-up: forced flush on the same set, strobe every cycle
    i_div = 16'd0;
    request(2'd2, 20);
    cnt = 0; cnt2 = 0;
    for (int i = 0; i < 60 && !o_valid; i++) begin step(); cnt += int'(o_fir_en); cnt2 = i; end
    check("warm_valid_seen", {1'b0, o_valid}, 2'b01);
    check_int("warm_strobes_to_valid", cnt, WARM_N + int'(LAT));
    steps(10);

    // run drop beats band request in the same cycle
    i_run      = 1'b0;
    i_band_sel = 2'd0;
    i_band_req = 1'b1;
    step();
    check("prio_no_ack", {1'b0, o_band_ack}, 2'b00);
    check("prio_srst",   {1'b0, o_fir_srst}, 2'b01);
    step();
    check("prio_idle_ack", {1'b0, o_band_ack}, 2'b01);
    check("prio_coeff",    o_coeff_sel, 2'd0);
    i_band_req = 1'b0;
    steps(2);

    // asynchronous reset in the middle of a flush
    i_run = 1'b1;
    steps(3);
    #2 i_rst = 1'b1;
    #1 model_reset();
    check_all();
    check("rst_coeff", o_coeff_sel, 2'd1);
    step();
    i_rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin step(); cnt += int'(o_fir_srst); end
    check_int("post_rst_flush", cnt, int'(FLUSH_CYC));

    // random traffic
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 5))
        0: begin i_div = CNT_WW'($urandom_range(0, 6)); steps(int'($urandom_range(1, 10))); end
        1: request(2'($urandom_range(0, 2)), 50);
        2: begin
          i_band_sel = 2'd3;
          i_band_req = 1'b1;
          steps(int'($urandom_range(1, 3)));
          i_band_req = 1'b0;
        end
        3: begin
          i_run = 1'b0;
          steps(int'($urandom_range(1, 4)));
          i_run = 1'b1;
        end
        default: steps(int'($urandom_range(5, 15)));
      endcase
    end
    steps(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
